// File: rtl/adau_spi_sequencer.sv
// Plays the fixed ADAU1761 init table into adau_spi_master, then forwards host register writes.
// Host forwarding exists only when ADAU_SEQ_HOST_EN is defined; otherwise RUN is terminal.
module adau_spi_sequencer #(
    parameter int unsigned WAIT_CYCLES = 120000,
    parameter int unsigned WAIT_AFTER  = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] spi_data,
    output logic        spi_valid,
    input  logic        spi_ready,
    input  logic [31:0] host_data,
    input  logic        host_valid,
    output logic        host_ready,
    output logic        init_done,
    output logic        busy
);
    localparam int unsigned    CntW    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);
    localparam logic [2:0]     IdxWait = 3'(WAIT_AFTER);
    localparam logic [2:0]     IdxLast = 3'd5;

    typedef enum logic [2:0] {
        StInitIssue,
        StInitDrain,
        StInitWait,
        StRun,
        StHostIssue,
        StHostDrain
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            seen_low_q, seen_low_d;
    logic            armed_q;
    logic [31:0]     spi_data_q, spi_data_d;
    logic            spi_valid_q, spi_valid_d;
    logic            host_ready_q, host_ready_d;
    logic            init_done_q, init_done_d;
    logic            busy_q, busy_d;

    function automatic logic [31:0] init_word(input logic [2:0] i);
        case (i)
            3'd3:    return 32'h0040_0001;
            3'd4:    return 32'h0040_F97F;
            3'd5:    return 32'h0040_FA03;
            default: return 32'h0040_0000;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        seen_low_d = seen_low_q;
        spi_data_d = spi_data_q;

        unique case (state_q)
            StInitIssue: begin
                if (spi_valid_q && spi_ready) begin
                    state_d    = StInitDrain;
                    seen_low_d = 1'b0;
                end
            end
            // The master must drop ready and raise it again before the next word goes out.
            StInitDrain: begin
                if (!spi_ready) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    if (idx_q == IdxWait) begin
                        state_d = StInitWait;
                        cnt_d   = '0;
                    end else if (idx_q == IdxLast) begin
                        state_d = StRun;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StInitIssue;
                    end
                end
            end
            StInitWait: begin
                if (cnt_q == CntLast) begin
                    if (idx_q == IdxLast) begin
                        state_d = StRun;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StInitIssue;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
`ifdef ADAU_SEQ_HOST_EN
                if (host_valid && host_ready_q) begin
                    state_d    = StHostIssue;
                    spi_data_d = host_data;
                end
`endif
            end
`ifdef ADAU_SEQ_HOST_EN
            StHostIssue: begin
                if (spi_valid_q && spi_ready) begin
                    state_d    = StHostDrain;
                    seen_low_d = 1'b0;
                end
            end
            StHostDrain: begin
                if (!spi_ready) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    state_d = StRun;
                end
            end
`endif
            default: state_d = StInitIssue;
        endcase

        if (state_d == StInitIssue) begin
            spi_data_d = init_word(idx_d);
        end

        // armed_q holds valid low for the first cycle out of reset.
        spi_valid_d = armed_q && (state_d == StInitIssue || state_d == StHostIssue);
        busy_d      = (state_d != StRun);
        init_done_d = init_done_q || (state_d == StRun);
`ifdef ADAU_SEQ_HOST_EN
        host_ready_d = (state_d == StRun);
`else
        host_ready_d = 1'b0;
`endif
    end

`ifndef ADAU_SEQ_HOST_EN
    logic unused_host;
    assign unused_host = ^{host_data, host_valid};
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StInitIssue;
            idx_q        <= '0;
            cnt_q        <= '0;
            seen_low_q   <= 1'b0;
            armed_q      <= 1'b0;
            spi_data_q   <= '0;
            spi_valid_q  <= 1'b0;
            host_ready_q <= 1'b0;
            init_done_q  <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            seen_low_q   <= seen_low_d;
            armed_q      <= 1'b1;
            spi_data_q   <= spi_data_d;
            spi_valid_q  <= spi_valid_d;
            host_ready_q <= host_ready_d;
            init_done_q  <= init_done_d;
            busy_q       <= busy_d;
        end
    end

    assign spi_data   = spi_data_q;
    assign spi_valid  = spi_valid_q;
    assign host_ready = host_ready_q;
    assign init_done  = init_done_q;
    assign busy       = busy_q;

endmodule
